// File: rtl/out_writeback_pkg.sv
// rtl/out_writeback_pkg.sv - shared sizes, FSM states and edge-tile clamp helper for out_writeback
package out_writeback_pkg;

   localparam int ARRAY     = 4;
   localparam int DATA_SIZE = 8;
   localparam int ACC_SIZE  = 16;
   localparam int WORD_SIZE = ARRAY * DATA_SIZE;
   localparam int ADDR_SIZE = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_DONE
   } wb_state_t;

   // Valid extent of a tile: 0 when the tile starts past the matrix edge, else min(ARRAY, total-base).
   function automatic logic [2:0] clamp_vld(input logic [4:0] total, input logic [4:0] base);
      logic [4:0] diff;
      diff = total - base;
      if (total <= base)
         return 3'd0;
      else if (diff >= 5'(ARRAY))
         return 3'(ARRAY);
      else
         return diff[2:0];
   endfunction

endpackage

// File: rtl/out_writeback_if.sv
// rtl/out_writeback_if.sv - GBUFF_OUT write port bundle
interface out_writeback_if;
   import out_writeback_pkg::*;

   logic                 gbuff_wr_en;
   logic [ADDR_SIZE-1:0] gbuff_index;
   logic [WORD_SIZE-1:0] gbuff_data;
   logic                 gbuff_wr_rdy;

   modport master (
      output gbuff_wr_en,
      output gbuff_index,
      output gbuff_data,
      input  gbuff_wr_rdy
   );

   modport slave (
      input  gbuff_wr_en,
      input  gbuff_index,
      input  gbuff_data,
      output gbuff_wr_rdy
   );

endinterface

// File: rtl/out_writeback_wb_row_pack.sv
// rtl/out_writeback_wb_row_pack.sv - truncates one PE row to bytes and packs it, column 0 in the top byte
module wb_row_pack
   import out_writeback_pkg::*;
(
   input  logic [ARRAY*ACC_SIZE-1:0] acc_row,
   input  logic [2:0]                cols_vld,
   output logic [WORD_SIZE-1:0]      word
);

   always_comb begin
      word = '0;
      for (int c = 0; c < ARRAY; c++) begin
         if (c < 32'(cols_vld))
            word[WORD_SIZE-1-DATA_SIZE*c -: DATA_SIZE] = acc_row[c*ACC_SIZE +: DATA_SIZE];
      end
   end

endmodule

// File: rtl/out_writeback.sv
// rtl/out_writeback.sv - captures a finished PE tile and writes its valid rows to GBUFF_OUT
module out_writeback
   import out_writeback_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wb_start,
   input  logic [3:0]                      tile_row,
   input  logic [1:0]                      tile_col,
   input  logic [3:0]                      m,
   input  logic [3:0]                      n,
   input  logic [ARRAY*ARRAY*ACC_SIZE-1:0] pe_res,
   out_writeback_if.master                 gb,
   output logic                            wb_busy,
   output logic                            wb_done
);

   wb_state_t                       state, state_nxt;
   logic [ARRAY*ARRAY*ACC_SIZE-1:0] pe_cap;
   logic [3:0]                      tile_row_q, m_q;
   logic [1:0]                      tile_col_q;
   logic [2:0]                      rows_vld_q, cols_vld_q;
   logic [2:0]                      rows_vld_d, cols_vld_d;
   logic [1:0]                      row_cnt;
   logic                            accept, last_row;
   logic [ARRAY*ACC_SIZE-1:0]       acc_row;
   logic [WORD_SIZE-1:0]            row_word;
   logic [ADDR_SIZE-1:0]            row_index;

   assign rows_vld_d = clamp_vld({1'b0, m}, {1'b0, tile_row});
   assign cols_vld_d = clamp_vld({1'b0, n}, {1'b0, tile_col, 2'b00});
   assign accept     = (state == ST_WRITE) && gb.gbuff_wr_rdy;
   assign last_row   = ({1'b0, row_cnt} == rows_vld_q - 3'd1);
   assign acc_row    = pe_cap[32'(row_cnt)*ARRAY*ACC_SIZE +: ARRAY*ACC_SIZE];
   // Column tiles are stored column-major in GBUFF_OUT, m rows per tile column.
   assign row_index  = ADDR_SIZE'(tile_col_q) * ADDR_SIZE'(m_q)
                     + ADDR_SIZE'(tile_row_q) + ADDR_SIZE'(row_cnt);

   wb_row_pack u_row_pack (
      .acc_row  (acc_row),
      .cols_vld (cols_vld_q),
      .word     (row_word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (wb_start)
               state_nxt = (rows_vld_d == 3'd0 || cols_vld_d == 3'd0) ? ST_DONE : ST_WRITE;
         end
         ST_WRITE: begin
            if (accept && last_row)
               state_nxt = ST_DONE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pe_cap     <= '0;
         tile_row_q <= '0;
         tile_col_q <= '0;
         m_q        <= '0;
         rows_vld_q <= '0;
         cols_vld_q <= '0;
         row_cnt    <= '0;
      end else if (state == ST_IDLE && wb_start) begin
         pe_cap     <= pe_res;
         tile_row_q <= tile_row;
         tile_col_q <= tile_col;
         m_q        <= m;
         rows_vld_q <= rows_vld_d;
         cols_vld_q <= cols_vld_d;
         row_cnt    <= '0;
      end else if (accept) begin
         row_cnt    <= row_cnt + 2'd1;
      end
   end

   always_comb begin
      gb.gbuff_wr_en = 1'b0;
      gb.gbuff_index = '0;
      gb.gbuff_data  = '0;
      wb_busy        = 1'b0;
      wb_done        = 1'b0;
      case (state)
         ST_WRITE: begin
            gb.gbuff_wr_en = 1'b1;
            gb.gbuff_index = row_index;
            gb.gbuff_data  = row_word;
            wb_busy        = 1'b1;
         end
         ST_DONE: begin
            wb_busy = 1'b1;
            wb_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_out_writeback.sv
// tb/tb_out_writeback.sv - scoreboard bench for out_writeback
module tb_out_writeback;
   import out_writeback_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         wb_start = 1'b0;
   logic [3:0]   tile_row = '0;
   logic [1:0]   tile_col = '0;
   logic [3:0]   m = '0;
   logic [3:0]   n = '0;
   logic [255:0] pe_res = '0;
   logic         wb_busy, wb_done;

   out_writeback_if gb_if();

   out_writeback dut (
      .clk      (clk),
      .rst      (rst),
      .wb_start (wb_start),
      .tile_row (tile_row),
      .tile_col (tile_col),
      .m        (m),
      .n        (n),
      .pe_res   (pe_res),
      .gb       (gb_if),
      .wb_busy  (wb_busy),
      .wb_done  (wb_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          checks = 0;
   int          errors = 0;
   int          n_wr = 0;
   int          done_cnt = 0;
   int          done_edge = 0;
   logic [39:0] exp_q[$];
   logic [15:0] pe[4][4];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Writes are retired on the falling edge; a stalled write must hold the head entry.
   always @(negedge clk) begin
      logic [39:0] e;
      if (rst && gb_if.gbuff_wr_en) begin
         if (exp_q.size() == 0) begin
            check("no_spurious_write", gb_if.gbuff_wr_en, 1'b0);
         end else if (gb_if.gbuff_wr_rdy) begin
            e = exp_q.pop_front();
            check("wr_index", gb_if.gbuff_index, e[39:32]);
            check("wr_data", gb_if.gbuff_data, e[31:0]);
            n_wr++;
         end else begin
            e = exp_q[0];
            check("hold_index", gb_if.gbuff_index, e[39:32]);
            check("hold_data", gb_if.gbuff_data, e[31:0]);
         end
      end
   end

   always @(negedge clk) begin
      if (rst && wb_done) begin
         done_cnt++;
         done_edge = cyc + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_pe(input int base);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            pe[r][c] = 16'(base + 16*r + c);
   endtask

   task automatic pack_pe();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            pe_res[(r*4+c)*16 +: 16] = pe[r][c];
   endtask

   task automatic push_expected(input int tr, input int tc, input int mm, input int nn,
                                output int rows);
      int          rv, cv;
      logic [31:0] word;
      logic [7:0]  idx;
      rv = mm - tr;
      cv = nn - 4*tc;
      if (rv > 4) rv = 4;
      if (cv > 4) cv = 4;
      if (rv < 0) rv = 0;
      if (cv <= 0) rv = 0;
      for (int r = 0; r < rv; r++) begin
         word = '0;
         for (int c = 0; c < cv; c++)
            word[31-8*c -: 8] = pe[r][c][7:0];
         idx = 8'(tc*mm + tr + r);
         exp_q.push_back({idx, word});
      end
      rows = rv;
   endtask

   task automatic run_tile(input string name, input int tr, input int tc, input int mm,
                           input int nn, input int stall_lo, input int stall_hi,
                           input bit dbl, input int exp_lat);
      int rows, t, d0, w0;
      pack_pe();
      push_expected(tr, tc, mm, nn, rows);
      tile_row = 4'(tr);
      tile_col = 2'(tc);
      m        = 4'(mm);
      n        = 4'(nn);
      wb_start = 1'b1;
      tick();
      t = cyc;
      wb_start = 1'b0;
      for (int i = 0; i < 8; i++) pe_res[i*32 +: 32] = $urandom();
      d0 = done_cnt;
      w0 = n_wr;
      for (int k = 0; k < 40 && done_cnt == d0; k++) begin
         gb_if.gbuff_wr_rdy = !((cyc+1) >= t+stall_lo && (cyc+1) <= t+stall_hi);
         if (dbl && k == 1) begin
            wb_start = 1'b1;
            tile_row = 4'd0;
            tile_col = 2'd0;
            m        = 4'd15;
            n        = 4'd15;
         end else begin
            wb_start = 1'b0;
         end
         tick();
      end
      wb_start = 1'b0;
      gb_if.gbuff_wr_rdy = 1'b1;
      check({name, "_done_seen"}, done_cnt - d0, 1);
      if (exp_lat >= 0)
         check({name, "_done_lat"}, done_edge - t, exp_lat);
      else if (rows > 0)
         check({name, "_done_lat"}, done_edge - t, rows + 1);
      else
         check({name, "_empty_done_lat_le2"}, (done_edge - t) <= 2, 1'b1);
      repeat (3) tick();
      check({name, "_writes"}, n_wr - w0, rows);
      check({name, "_queue_empty"}, exp_q.size(), 0);
      check({name, "_single_done"}, done_cnt - d0, 1);
   endtask

   initial begin
      int rows, t, d0;
      gb_if.gbuff_wr_rdy = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("rst_wr_en", gb_if.gbuff_wr_en, 0);
      check("rst_index", gb_if.gbuff_index, 0);
      check("rst_data", gb_if.gbuff_data, 0);
      check("rst_busy", wb_busy, 0);
      check("rst_done", wb_done, 0);
      tick();
      rst = 1'b1;
      tick();

      set_pe(0);
      run_tile("full", 0, 0, 4, 4, 0, -1, 1'b0, 5);
      set_pe(0);
      run_tile("partial", 0, 0, 3, 2, 0, -1, 1'b0, 4);
      set_pe(0);
      pe[0][0] = 16'h01FF;
      run_tile("trunc", 0, 0, 4, 4, 0, -1, 1'b0, 5);
      set_pe(16'h40);
      run_tile("stall", 0, 0, 4, 4, 2, 4, 1'b0, 8);
      set_pe(16'h80);
      run_tile("offset", 4, 1, 8, 8, 0, -1, 1'b1, 5);
      set_pe(16'h1A5);
      run_tile("edge_cols", 0, 2, 5, 10, 0, -1, 1'b0, -1);

      // Reset lands while row 2 is on the bus.
      set_pe(0);
      pack_pe();
      push_expected(0, 0, 4, 4, rows);
      tile_row = 4'd0; tile_col = 2'd0; m = 4'd4; n = 4'd4;
      wb_start = 1'b1;
      tick();
      t = cyc;
      wb_start = 1'b0;
      for (int k = 0; k < 10 && cyc < t + 2; k++) tick();
      rst = 1'b0;
      d0 = done_cnt;
      @(negedge clk);
      check("mid_rst_wr_en", gb_if.gbuff_wr_en, 0);
      check("mid_rst_index", gb_if.gbuff_index, 0);
      check("mid_rst_data", gb_if.gbuff_data, 0);
      check("mid_rst_busy", wb_busy, 0);
      check("mid_rst_done", wb_done, 0);
      exp_q.delete();
      tick();
      rst = 1'b1;
      repeat (6) tick();
      check("mid_rst_no_done", done_cnt - d0, 0);

      set_pe(16'h3C);
      run_tile("after_rst", 0, 0, 4, 4, 0, -1, 1'b0, 5);
      run_tile("empty", 8, 0, 4, 4, 0, -1, 1'b0, -1);

      for (int i = 0; i < 4; i++) begin
         set_pe(int'($urandom_range(0, 16'hFFFF)));
         run_tile("rand", 4*int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(1, 15)), int'($urandom_range(1, 15)), 0, -1, 1'b0, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
